// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: FSM states and R/W encodings shared by the SPI burst memory
package spi_mem_pkg;
   typedef enum logic [2:0] {IDLE, HEADER, WR_DATA, RD_LOAD, RD_DATA} spi_state_e;
   localparam logic SPI_READ = 1'b1;
   localparam logic SPI_WRITE = 1'b0;
endpackage

// File: rtl/spi_burst_memory_if.sv
// spi_burst_memory_if: raw SPI pins plus MISO output-enable
interface spi_burst_memory_if;
   logic sclk_pin, cs_pin, mosi_pin, miso_pin, miso_en;
   modport master(output sclk_pin, cs_pin, mosi_pin, input miso_pin, miso_en);
   modport slave(input sclk_pin, cs_pin, mosi_pin, output miso_pin, miso_en);
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop pin synchroniser with rise/fall pulses
module spi_pin_sync #(
   parameter int STAGES = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync <= {STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   assign q = sync[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/spi_burst_memory.sv
// spi_burst_memory: SPI-slave register-array memory with auto-incrementing bursts
module spi_burst_memory
   import spi_mem_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int DEPTH = 2**ADDR_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   spi_burst_memory_if.slave spi,
   output logic [3:0] leds,
   output logic busy
);
   localparam int CNT_W = $clog2((ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W) + 1;
   logic sclk_q, sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q, mosi_rise, mosi_fall;
   logic unused_ok;
   spi_state_e state;
   logic [CNT_W-1:0] cnt;
   logic [ADDR_W-1:0] addr, addr_inc, hdr;
   logic [DATA_W-1:0] shift_in, shift_out, nxt;
   logic wr_pend, last;
   logic [DATA_W-1:0] mem [DEPTH];
   spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .d(spi.sclk_pin), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
   spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst_n(rst_n), .d(spi.cs_pin), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
   spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst_n(rst_n), .d(spi.mosi_pin), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
   assign unused_ok = ^{sclk_q, cs_rise, mosi_rise, mosi_fall};
   assign addr_inc = (32'(addr) == DEPTH - 1) ? '0 : addr + 1'b1;
   assign last = cnt == CNT_W'(DATA_W - 1);
   assign busy = state != IDLE;
   always_ff @(posedge clk)
      if (wr_pend) mem[addr] <= shift_in;
   // cs high is checked first so a coincident sclk edge never advances the frame
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         addr <= '0;
         hdr <= '0;
         shift_in <= '0;
         shift_out <= '0;
         nxt <= '0;
         wr_pend <= 1'b0;
         leds <= '0;
         spi.miso_pin <= 1'b0;
         spi.miso_en <= 1'b0;
      end else begin
         wr_pend <= 1'b0;
         if (wr_pend) begin
            leds <= shift_in[3:0];
            addr <= addr_inc;
         end
         if (cs_q) begin
            state <= IDLE;
            cnt <= '0;
            spi.miso_pin <= 1'b0;
            spi.miso_en <= 1'b0;
         end else begin
            case (state)
               IDLE: if (cs_fall) begin
                  state <= HEADER;
                  cnt <= '0;
               end
               HEADER: if (sclk_rise) begin
                  hdr <= {hdr[ADDR_W-2:0], mosi_q};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(ADDR_W)) begin
                     addr <= ADDR_W'(32'(hdr) % DEPTH);
                     state <= (mosi_q == SPI_READ) ? RD_LOAD : WR_DATA;
                     cnt <= '0;
                  end
               end
               WR_DATA: if (sclk_rise) begin
                  shift_in <= {shift_in[DATA_W-2:0], mosi_q};
                  cnt <= last ? '0 : cnt + 1'b1;
                  wr_pend <= last;
               end
               RD_LOAD: begin
                  shift_out <= mem[addr];
                  spi.miso_en <= 1'b1;
                  state <= RD_DATA;
               end
               RD_DATA: if (sclk_fall) begin
                  spi.miso_pin <= shift_out[DATA_W-1];
                  shift_out <= last ? nxt : shift_out << 1;
                  cnt <= last ? '0 : cnt + 1'b1;
                  // presenting the MSB advances the address and prefetches the following word
                  if (cnt == '0) begin
                     addr <= addr_inc;
                     nxt <= mem[addr_inc];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
endmodule
